// File: rtl/tdm_pkg.sv
// Shared TDM link constants and FSM state type, used by both ends of the link.
package tdm_pkg;
   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } tdm_state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// 3-bit TDM slot counter: clear, load-to-1 (resync), increment, terminal-count flag.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot,
   output logic              tc
);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   always_comb begin
      slot_d = slot_q;
      if (clr) begin
         slot_d = '0;
      end else if (load1) begin
         slot_d = SLOT_W'(1);
      end else if (inc) begin
         slot_d = slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;
   assign tc   = (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux_1x8.sv
// Receive-side 1:8 TDM demultiplexer: slot-routed shadow register, framing FSM,
// and a registered parallel frame output with a one-cycle valid pulse.
module tdm_demux_1x8
   import tdm_pkg::*;
#(
   parameter bit REQUIRE_SYNC = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 en,
   input  logic                 frame,
   output logic [NUM_SLOTS-1:0] y,
   output logic                 y_valid,
   output logic [SLOT_W-1:0]    slot,
   output logic                 sync_err
);

   tdm_state_e           state_q, state_d;
   logic [NUM_SLOTS-1:0] shadow_q, shadow_d;
   logic [NUM_SLOTS-1:0] y_q, y_d;
   logic                 y_valid_q, y_valid_d;
   logic                 sync_err_q, sync_err_d;

   logic                 cnt_clr;
   logic                 cnt_load1;
   logic                 cnt_inc;
   logic [SLOT_W-1:0]    slot_cur;
   logic                 slot_tc;

   tdm_slot_counter u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .slot  (slot_cur),
      .tc    (slot_tc)
   );

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      y_d        = y_q;
      y_valid_d  = 1'b0;
      sync_err_d = 1'b0;
      cnt_clr    = 1'b0;
      cnt_load1  = 1'b0;
      cnt_inc    = 1'b0;

      if (en) begin
         unique case (state_q)
            HUNT: begin
               if (frame) begin
                  shadow_d[0] = din;
                  cnt_load1   = 1'b1;
                  state_d     = RUN;
               end
            end
            RUN: begin
               if (frame && (slot_cur != '0)) begin
                  // Early frame: the stale partial frame is simply overwritten.
                  sync_err_d  = 1'b1;
                  shadow_d[0] = din;
                  cnt_load1   = 1'b1;
               end else if (!frame && (slot_cur == '0) && REQUIRE_SYNC) begin
                  sync_err_d = 1'b1;
                  cnt_clr    = 1'b1;
                  state_d    = HUNT;
               end else begin
                  shadow_d[slot_cur] = din;
                  cnt_inc            = 1'b1;
                  if (slot_tc) begin
                     y_d       = {din, shadow_q[NUM_SLOTS-2:0]};
                     y_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= REQUIRE_SYNC ? HUNT : RUN;
         shadow_q   <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign y        = y_q;
   assign y_valid  = y_valid_q;
   assign slot     = slot_cur;
   assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Bench for tdm_demux_1x8: two instances (REQUIRE_SYNC=1 and 0) sharing one input
// stream, checked against a frame-level reference model plus directed expectations.
module tb_tdm_demux_1x8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       frame = 1'b0;
   logic       din = 1'b0;
   logic [7:0] y0, y1;
   logic       yv0, yv1, se0, se1;
   logic [2:0] slot0, slot1;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state, index 0 = REQUIRE_SYNC=1, index 1 = REQUIRE_SYNC=0
   bit         m_req[2] = '{1'b1, 1'b0};
   bit         m_hunt[2];
   int         m_cnt[2];
   logic [7:0] m_acc[2];
   logic [7:0] m_y[2];
   bit         m_yv[2];
   bit         m_se[2];

   tdm_demux_1x8 #(.REQUIRE_SYNC(1'b1)) u0 (
      .clk(clk), .rst(rst), .din(din), .en(en), .frame(frame),
      .y(y0), .y_valid(yv0), .slot(slot0), .sync_err(se0)
   );

   tdm_demux_1x8 #(.REQUIRE_SYNC(1'b0)) u1 (
      .clk(clk), .rst(rst), .din(din), .en(en), .frame(frame),
      .y(y1), .y_valid(yv1), .slot(slot1), .sync_err(se1)
   );

   always #5 clk = ~clk;

   function automatic void model_step(int i, bit r, bit e, bit f, bit d);
      m_yv[i] = 1'b0;
      m_se[i] = 1'b0;
      if (r) begin
         m_y[i] = 8'h00; m_cnt[i] = 0; m_acc[i] = 8'h00; m_hunt[i] = m_req[i];
      end else if (e) begin
         if (m_hunt[i]) begin
            if (f) begin
               m_acc[i] = {7'b0, d}; m_cnt[i] = 1; m_hunt[i] = 1'b0;
            end
         end else if (f && m_cnt[i] != 0) begin
            m_se[i] = 1'b1; m_acc[i] = {7'b0, d}; m_cnt[i] = 1;
         end else if (!f && m_cnt[i] == 0 && m_req[i]) begin
            m_se[i] = 1'b1; m_hunt[i] = 1'b1;
         end else begin
            m_acc[i] = m_acc[i] | (8'(d) << m_cnt[i]);
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == 8) begin
               m_y[i] = m_acc[i]; m_yv[i] = 1'b1; m_cnt[i] = 0; m_acc[i] = 8'h00;
            end
         end
      end
   endfunction

   task automatic cycle(input bit r, input bit e, input bit f, input bit d);
      rst = r; en = e; frame = f; din = d;
      @(posedge clk);
      model_step(0, r, e, f, d);
      model_step(1, r, e, f, d);
      #1;
   endtask

   function automatic logic [25:0] obs_all();
      return {y0, yv0, se0, slot0, y1, yv1, se1, slot1};
   endfunction

   function automatic logic [25:0] exp_all();
      return {m_y[0], m_yv[0], m_se[0], 3'(m_cnt[0]), m_y[1], m_yv[1], m_se[1], 3'(m_cnt[1])};
   endfunction

   task automatic test_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 1, 1, 1);
      n_chk++;
      if ({y0, yv0, se0, slot0} !== 13'h0) begin
         n_fail++; $display("FAIL reset_state: got %h required 0", {y0, yv0, se0, slot0});
      end
      n_chk++;
      if (obs_all() !== exp_all()) begin
         n_fail++; $display("FAIL reset_model: got %h required %h", obs_all(), exp_all());
      end
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1, 0, 1'($urandom % 2));
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL idle_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if ({y0, yv0, se0, slot0} !== 13'h0) begin
         n_fail++; $display("FAIL idle_hunt: got %h required 0", {y0, yv0, se0, slot0});
      end
   endtask

   task automatic test_normal_frame();
      logic [7:0] v = 8'h4D;
      int pulses = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(0, 1, k == 0, v[k]);
         pulses += int'(yv0);
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL normal_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if (y0 !== 8'h4D || pulses != 1) begin
         n_fail++; $display("FAIL normal_frame: y=%h pulses=%0d required 4d and 1", y0, pulses);
      end
      cycle(0, 0, 0, 0);
      n_chk++;
      if (yv0 !== 1'b0 || slot0 !== 3'd0 || y0 !== 8'h4D) begin
         n_fail++; $display("FAIL normal_after: yv=%b slot=%0d y=%h required 0 0 4d", yv0, slot0, y0);
      end
   endtask

   task automatic test_gapped_strobe();
      logic [7:0] v = 8'h4D;
      int c = 0;
      int vcyc = -1;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            for (int g = 0; g < 3; g++) begin
               cycle(0, 0, 0, 1'($urandom % 2));
               c++;
               n_chk++;
               if (y0 !== 8'h4D || yv0 !== 1'b0 || slot0 !== 3'd4) begin
                  n_fail++; $display("FAIL gap_hold: y=%h yv=%b slot=%0d required 4d 0 4", y0, yv0, slot0);
               end
            end
         end
         cycle(0, 1, k == 0, v[k]);
         if (yv0) vcyc = c;
         c++;
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL gap_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if (vcyc != 10 || y0 !== 8'h4D) begin
         n_fail++; $display("FAIL gap_valid: cycle=%0d y=%h required 10 4d", vcyc, y0);
      end
   endtask

   task automatic test_early_frame();
      for (int k = 0; k < 5; k++) begin
         cycle(0, 1, k == 0, 1'b0);
      end
      cycle(0, 1, 1, 1);
      n_chk++;
      if (se0 !== 1'b1 || y0 !== 8'h4D || slot0 !== 3'd1 || yv0 !== 1'b0) begin
         n_fail++; $display("FAIL early_err: se=%b y=%h slot=%0d yv=%b required 1 4d 1 0", se0, y0, slot0, yv0);
      end
      for (int k = 1; k < 8; k++) begin
         cycle(0, 1, 0, 1);
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL early_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if (y0 !== 8'hFF || yv0 !== 1'b1 || se0 !== 1'b0) begin
         n_fail++; $display("FAIL early_restart: y=%h yv=%b se=%b required ff 1 0", y0, yv0, se0);
      end
   endtask

   task automatic test_missing_frame();
      logic [7:0] v = 8'h3D;
      logic [7:0] w = 8'h5A;
      int pulses0 = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(0, 1, 0, v[k]);
         pulses0 += int'(yv0);
         n_chk++;
         if (se0 !== (k == 0) || slot0 !== 3'd0) begin
            n_fail++; $display("FAIL missing_hunt k=%0d: se=%b slot=%0d required %b 0", k, se0, slot0, k == 0);
         end
      end
      n_chk++;
      if (pulses0 != 0 || y0 !== 8'hFF || y1 !== v || yv1 !== 1'b1 || se1 !== 1'b0) begin
         n_fail++; $display("FAIL missing_result: p0=%0d y0=%h y1=%h yv1=%b se1=%b required 0 ff 3d 1 0",
                            pulses0, y0, y1, yv1, se1);
      end
      for (int k = 0; k < 8; k++) begin
         cycle(0, 1, k == 0, w[k]);
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL resync_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if (y0 !== 8'h5A || yv0 !== 1'b1) begin
         n_fail++; $display("FAIL resync_frame: y=%h yv=%b required 5a 1", y0, yv0);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] v = 8'hA5;
      for (int k = 0; k < 4; k++) cycle(0, 1, k == 0, 1'b1);
      cycle(1, 1, 0, 1);
      n_chk++;
      if (y0 !== 8'h00 || slot0 !== 3'd0 || yv0 !== 1'b0 || y1 !== 8'h00) begin
         n_fail++; $display("FAIL midreset: y0=%h slot=%0d yv=%b y1=%h required 00 0 0 00", y0, slot0, yv0, y1);
      end
      for (int k = 0; k < 8; k++) begin
         cycle(0, 1, k == 0, v[k]);
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL midreset_model: got %h required %h", obs_all(), exp_all());
         end
      end
      n_chk++;
      if (y0 !== 8'hA5 || yv0 !== 1'b1) begin
         n_fail++; $display("FAIL midreset_frame: y=%h yv=%b required a5 1", y0, yv0);
      end
      for (int k = 0; k < 7; k++) cycle(0, 1, k == 0, 1'b1);
      cycle(1, 1, 0, 1);
      n_chk++;
      if (y0 !== 8'h00 || yv0 !== 1'b0 || slot0 !== 3'd0) begin
         n_fail++; $display("FAIL reset_vs_slot7: y=%h yv=%b slot=%0d required 00 0 0", y0, yv0, slot0);
      end
   endtask

   task automatic test_random();
      bit r, e, f;
      for (int k = 0; k < 800; k++) begin
         r = ($urandom % 150) == 0;
         e = ($urandom % 4) != 0;
         f = (m_cnt[0] == 0) ? (($urandom % 8) != 0) : (($urandom % 20) == 0);
         cycle(r, e, f, 1'($urandom % 2));
         n_chk++;
         if (obs_all() !== exp_all()) begin
            n_fail++; $display("FAIL random_model k=%0d: got %h required %h", k, obs_all(), exp_all());
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_gapped_strobe();
      test_early_frame();
      test_missing_frame();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Receive-side time-division demultiplexer: recovers eight 1-bit lanes from a serial slot stream produced by a counter-driven 8:1 selector, where slot k carries lane k. Each accepted sample is routed by a 3-bit slot counter into a shadow register. The completed 8-bit frame is presented in parallel with a one-cycle valid pulse. Sits at the far end of the TDM link, feeding downstream parallel logic.

## Interface
- `REQUIRE_SYNC`, default 1: when 1, `frame` must be high on every slot-0 sample; when 0, `frame` is only used to resynchronise.
- `clk`  in  1  sole clock, all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  serial slot data.
- `en`  in  1  sample strobe; `din` and `frame` are only sampled when `en`=1.
- `frame`  in  1  marks the sample carrying slot 0.
- `y`  out  8  last complete frame; `y[k]` = slot-k bit.
- `y_valid`  out  1  one-cycle pulse when `y` is updated.
- `slot`  out  3  slot index expected for the next sample.
- `sync_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- **States:** HUNT, RUN.
- **Reset:**
  - `y`=0, `y_valid`=0, `sync_err`=0, `slot`=0, shadow=0.
  - State goes to HUNT if `REQUIRE_SYNC`=1, otherwise RUN.
- **HUNT:**
  - Samples with `frame`=0 are discarded.
  - On `en`&`frame`: shadow[0] gets `din`, `slot` goes to 1, state goes to RUN.
- **RUN:** on `en`, evaluated in this priority order:
  1. `frame`=1 and `slot`≠0: pulse `sync_err`, discard the partial frame, shadow[0] gets `din`, `slot` goes to 1. Stay in RUN.
  2. `frame`=0, `slot`=0, `REQUIRE_SYNC`=1: pulse `sync_err`, discard the sample, go to HUNT, `slot` stays 0.
  3. Otherwise shadow[`slot`] gets `din` and `slot` increments.
     - At `slot`=7: `y` gets {`din`, shadow[6:0]}, `y_valid` pulses, `slot` wraps to 0.
- **Hold behaviour:**
  - `en`=0: no state change; `y_valid` and `sync_err` read 0.
  - `y` holds its value until the next complete frame.
  - A discarded partial frame never reaches `y`.
- **Reset mid-frame:** partial data is lost and `y` is cleared to 0. No `y_valid` is produced.
- **Widths:** `slot` is 3-bit and wraps modulo 8, with no overflow state.

## Timing
- All outputs are registered.
- `y` and `y_valid` change on the same edge that samples slot 7, so they are visible the cycle after the slot-7 sample is presented.
- `sync_err` is asserted in the cycle after the offending sample.
- Throughput: one frame per 8 accepted samples. Back-to-back `en` is allowed, giving a `y_valid` every 8th cycle at minimum.
- `rst` takes priority over `en`.
- Simultaneous `rst` and slot-7 sample: reset wins, and there is no `y_valid`.

## Structure
- Package `tdm_pkg` holds:
  - `NUM_SLOTS` = 8 and `SLOT_W` = 3.
  - The state enum {HUNT, RUN}.
  - These are shared with the transmit-side slot counter.
- Sub-module `tdm_slot_counter`: a 3-bit counter with synchronous clear/load-to-1, increment-on-enable, and a terminal-count flag (`slot`=7).
- Top level holds the FSM, shadow register and output registers.

## Test plan
- **Reset and idle:** reset, then drive `en`=1 with `frame`=0 for 10 cycles (`REQUIRE_SYNC`=1). Required: `y`=0x00, no `y_valid`, no `sync_err`, `slot`=0.
- **Normal frame:** frame at slot 0, then `din` sequence slots 0..7 = 1,0,1,1,0,0,1,0. Required: `y`=0x4D with one `y_valid` pulse, then `slot`=0.
- **Gapped strobe:** same frame with `en` low for 3 cycles between slots 3 and 4. Required: `y`=0x4D, `y_valid` delayed by exactly 3 cycles, `y` unchanged during the gap.
- **Early frame:** `frame` asserted at `slot`=5. Required:
  - `sync_err` pulse.
  - The prior `y` is retained.
  - Sampling restarts, so the next 8 samples (0xFF) give `y`=0xFF.
- **Missing frame:**
  - With `REQUIRE_SYNC`=1, `frame`=0 at slot 0 gives `sync_err` and HUNT; no `y_valid` until the next `frame`.
  - With `REQUIRE_SYNC`=0, the frame completes normally.
- **Reset mid-frame:** `rst` at slot 4. Required: `y`=0, `slot`=0, no `y_valid`; the next full frame 0xA5 gives `y`=0xA5.
